// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath control sequencer: opcodes, register
// selects, sequencer states and the registered control word.
package datapath_ctrl_pkg;

  localparam int CW_IMM_W   = 8;
  localparam int CW_INSTR_W = CW_IMM_W + 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDIA = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_MV   = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP1 = 2'd1,
    ST_STEP2 = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic                ra_in;
    logic                rb_in;
    logic                rz_in;
    logic                ra_out;
    logic                rb_out;
    logic                rz_out;
    logic [CW_IMM_W-1:0] add_imm;
    logic [CW_IMM_W-1:0] rega_imm;
  } ctrl_word_t;

  // Only A and B exist; selects 2 and 3 make the instruction illegal.
  function automatic logic sel_legal(input logic [1:0] sel);
    return (sel == SEL_A) || (sel == SEL_B);
  endfunction

endpackage

// File: rtl/datapath_ctrl_decode.sv
// Combinational decode: from the current state and the instruction being
// executed, produce the control word, done/err and state for the next cycle.
// Build option: DATAPATH_CTRL_DIRECT_MV_EN makes MV a single-step direct
// register-to-register transfer instead of routing through Z.
module datapath_ctrl_decode
  import datapath_ctrl_pkg::*;
(
  input  state_t                  state,
  input  logic                    accept,
  input  logic [CW_INSTR_W-1:0]   instr,
  output state_t                  state_next,
  output ctrl_word_t              cw_next,
  output logic                    done_next,
  output logic                    err_next
);

  logic [3:0]          opcode;
  logic [1:0]          rd;
  logic [1:0]          rs;
  logic [CW_IMM_W-1:0] imm;
  logic                regs_legal;

  assign opcode     = instr[CW_INSTR_W-1 -: 4];
  assign rd         = instr[CW_IMM_W+3 -: 2];
  assign rs         = instr[CW_IMM_W+1 -: 2];
  assign imm        = instr[CW_IMM_W-1:0];
  assign regs_legal = sel_legal(rd) && sel_legal(rs);

  // Next-state and next control word; everything defaults to idle/zero.
  always_comb begin
    state_next = state;
    cw_next    = '0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_STEP1;
          case (opcode)
            OP_NOP: done_next = 1'b1;
            OP_LDIA: begin
              cw_next.rega_imm = imm;
              cw_next.ra_in    = 1'b1;
              done_next        = 1'b1;
            end
            OP_ADDI, OP_MV: begin
              if (!regs_legal) begin
                err_next = 1'b1;
              end else begin
                cw_next.ra_out = (rs == SEL_A);
                cw_next.rb_out = (rs == SEL_B);
`ifdef DATAPATH_CTRL_DIRECT_MV_EN
                if (opcode == OP_MV) begin
                  // Direct bus transfer: rs drives, rd loads, Z untouched.
                  cw_next.ra_in = (rd == SEL_A);
                  cw_next.rb_in = (rd == SEL_B);
                  done_next     = 1'b1;
                end else begin
                  cw_next.add_imm = imm;
                  cw_next.rz_in   = 1'b1;
                end
`else
                // MV is ADDI with a zero immediate.
                if (opcode == OP_ADDI) cw_next.add_imm = imm;
                cw_next.rz_in = 1'b1;
`endif
              end
            end
            OP_HALT: state_next = ST_HALT;
            default: err_next = 1'b1;
          endcase
        end
      end
      ST_STEP1: begin
        state_next = ST_IDLE;
`ifdef DATAPATH_CTRL_DIRECT_MV_EN
        if ((opcode == OP_ADDI) && regs_legal) begin
`else
        if (((opcode == OP_ADDI) || (opcode == OP_MV)) && regs_legal) begin
`endif
          state_next     = ST_STEP2;
          cw_next.rz_out = 1'b1;
          cw_next.ra_in  = (rd == SEL_A);
          cw_next.rb_in  = (rd == SEL_B);
          done_next      = 1'b1;
        end
      end
      ST_STEP2: state_next = ST_IDLE;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Datapath control sequencer top: accepts one instruction over valid/ready,
// holds the state and all output registers, and steps the datapath one
// control word per clock. Build option: DATAPATH_CTRL_DIRECT_MV_EN selects
// single-step MV (see datapath_ctrl_decode).
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int IMM_W   = CW_IMM_W,
  parameter int INSTR_W = IMM_W + 8
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               RAin,
  output logic               RBin,
  output logic               RZin,
  output logic               RAout,
  output logic               RBout,
  output logic               RZout,
  output logic [IMM_W-1:0]   AddImmediate,
  output logic [IMM_W-1:0]   RegisterAImmediate,
  output logic               done,
  output logic               err,
  output logic               halted
);

  state_t                state_reg;
  state_t                state_next;
  logic [INSTR_W-1:0]    instr_reg;
  logic [INSTR_W-1:0]    dec_instr;
  ctrl_word_t            cw_reg;
  ctrl_word_t            cw_next;
  logic                  done_reg;
  logic                  done_next;
  logic                  err_reg;
  logic                  err_next;
  logic                  halted_reg;
  logic                  ready_reg;
  logic                  accept;

  assign accept = instr_valid && ready_reg;

  // In IDLE the first step decodes straight from the bus so controls appear
  // the cycle after acceptance; later steps use the latched copy.
  assign dec_instr = (state_reg == ST_IDLE) ? instr : instr_reg;

  datapath_ctrl_decode u_decode (
    .state      (state_reg),
    .accept     (accept),
    .instr      (dec_instr),
    .state_next (state_next),
    .cw_next    (cw_next),
    .done_next  (done_next),
    .err_next   (err_next)
  );

  // State, latched instruction and registered outputs.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_reg  <= ST_IDLE;
      instr_reg  <= '0;
      cw_reg     <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      halted_reg <= 1'b0;
      ready_reg  <= 1'b1;
    end else begin
      state_reg  <= state_next;
      if (accept) instr_reg <= instr;
      cw_reg     <= cw_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      halted_reg <= (state_next == ST_HALT);
      ready_reg  <= (state_next == ST_IDLE);
    end
  end

  assign instr_ready        = ready_reg;
  assign RAin               = cw_reg.ra_in;
  assign RBin               = cw_reg.rb_in;
  assign RZin               = cw_reg.rz_in;
  assign RAout              = cw_reg.ra_out;
  assign RBout              = cw_reg.rb_out;
  assign RZout              = cw_reg.rz_out;
  assign AddImmediate       = cw_reg.add_imm;
  assign RegisterAImmediate = cw_reg.rega_imm;
  assign done               = done_reg;
  assign err                = err_reg;
  assign halted             = halted_reg;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: table of instructions with expected per-cycle
// output words, a scoreboard queue, a small A/B/Z datapath model, and
// hand-written reset / busy / HALT sequences.
module tb_datapath_ctrl;

  logic        clk;
  logic        clear_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        RAin, RBin, RZin, RAout, RBout, RZout;
  logic [7:0]  AddImmediate, RegisterAImmediate;
  logic        done, err, halted;

  datapath_ctrl dut (
    .clock              (clk),
    .clear_n            (clear_n),
    .instr              (instr),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .RAin               (RAin),
    .RBin               (RBin),
    .RZin               (RZin),
    .RAout              (RAout),
    .RBout              (RBout),
    .RZout              (RZout),
    .AddImmediate       (AddImmediate),
    .RegisterAImmediate (RegisterAImmediate),
    .done               (done),
    .err                (err),
    .halted             (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word: {ready, RAin,RBin,RZin,RAout,RBout,RZout, add, rega, done, err, halted}
  logic [25:0] obs;
  assign obs = {instr_ready, RAin, RBin, RZin, RAout, RBout, RZout,
                AddImmediate, RegisterAImmediate, done, err, halted};

  localparam logic [5:0] C_RAIN  = 6'b100000;
  localparam logic [5:0] C_RBIN  = 6'b010000;
  localparam logic [5:0] C_RZIN  = 6'b001000;
  localparam logic [5:0] C_RAOUT = 6'b000100;
  localparam logic [5:0] C_RBOUT = 6'b000010;
  localparam logic [5:0] C_RZOUT = 6'b000001;

  function automatic logic [25:0] ow(input logic rdy, input logic [5:0] c,
                                     input logic [7:0] add, input logic [7:0] rega,
                                     input logic dn, input logic er, input logic hl);
    return {rdy, c, add, rega, dn, er, hl};
  endfunction

  // Small datapath model driven by the DUT's control outputs.
  logic [7:0] dp_a, dp_b, dp_z, bus;
  assign bus = RAout ? dp_a : RBout ? dp_b : RZout ? dp_z : 8'h00;
  always @(posedge clk) begin
    if (!clear_n) begin
      dp_a <= 8'h00; dp_b <= 8'h00; dp_z <= 8'h00;
    end else begin
      if (RAin) dp_a <= (RAout | RBout | RZout) ? bus : RegisterAImmediate;
      if (RBin) dp_b <= bus;
      if (RZin) dp_z <= bus + AddImmediate;
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  logic [25:0] sb_q[$];

  task automatic check_val(input string name, input logic [25:0] act, input logic [25:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_out(input string name);
    logic [25:0] e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got %h required <entry>", name, obs);
    end else begin
      e = sb_q.pop_front();
      check_val(name, obs, e);
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] ins;
    int          n;
    logic [25:0] e0, e1, e2;
  } vec_t;

  vec_t vecs[10];
  logic [25:0] w_idle;
  logic [25:0] w_halt;

  // Drive one instruction at a negedge, push its expected words, check each cycle.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    instr       = v.ins;
    instr_valid = 1'b1;
    sb_q.push_back(v.e0);
    if (v.n > 1) sb_q.push_back(v.e1);
    if (v.n > 2) sb_q.push_back(v.e2);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check_out({v.name, ".s1"});
    for (int k = 1; k < v.n; k++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("%s.c%0d", v.name, k + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w_idle = ow(1, 6'b0, 8'h00, 8'h00, 0, 0, 0);
    w_halt = ow(0, 6'b0, 8'h00, 8'h00, 0, 0, 1);

    vecs[0] = '{"ldia5",    16'h1005, 2, ow(0, C_RAIN, 8'h00, 8'h05, 1, 0, 0), w_idle, w_idle};
    vecs[1] = '{"addi_b_a", 16'h2405, 3, ow(0, C_RAOUT | C_RZIN, 8'h05, 8'h00, 0, 0, 0),
                                         ow(0, C_RZOUT | C_RBIN, 8'h00, 8'h00, 1, 0, 0), w_idle};
`ifdef DATAPATH_CTRL_DIRECT_MV_EN
    vecs[2] = '{"mv_a_b",   16'h3133, 2, ow(0, C_RBOUT | C_RAIN, 8'h00, 8'h00, 1, 0, 0), w_idle, w_idle};
    vecs[7] = '{"mv_a_a",   16'h3000, 2, ow(0, C_RAOUT | C_RAIN, 8'h00, 8'h00, 1, 0, 0), w_idle, w_idle};
`else
    vecs[2] = '{"mv_a_b",   16'h3133, 3, ow(0, C_RBOUT | C_RZIN, 8'h00, 8'h00, 0, 0, 0),
                                         ow(0, C_RZOUT | C_RAIN, 8'h00, 8'h00, 1, 0, 0), w_idle};
    vecs[7] = '{"mv_a_a",   16'h3000, 3, ow(0, C_RAOUT | C_RZIN, 8'h00, 8'h00, 0, 0, 0),
                                         ow(0, C_RZOUT | C_RAIN, 8'h00, 8'h00, 1, 0, 0), w_idle};
`endif
    vecs[3] = '{"nop",      16'h0000, 2, ow(0, 6'b0, 8'h00, 8'h00, 1, 0, 0), w_idle, w_idle};
    vecs[4] = '{"op7",      16'h7ABC, 2, ow(0, 6'b0, 8'h00, 8'h00, 0, 1, 0), w_idle, w_idle};
    vecs[5] = '{"addi_rd3", 16'h2C07, 2, ow(0, 6'b0, 8'h00, 8'h00, 0, 1, 0), w_idle, w_idle};
    vecs[6] = '{"addi_a_b", 16'h21FF, 3, ow(0, C_RBOUT | C_RZIN, 8'hFF, 8'h00, 0, 0, 0),
                                         ow(0, C_RZOUT | C_RAIN, 8'h00, 8'h00, 1, 0, 0), w_idle};
    vecs[8] = '{"ldia_aa",  16'h1FAA, 2, ow(0, C_RAIN, 8'h00, 8'hAA, 1, 0, 0), w_idle, w_idle};
    vecs[9] = '{"mv_rs2",   16'h3200, 2, ow(0, 6'b0, 8'h00, 8'h00, 0, 1, 0), w_idle, w_idle};

    clear_n     = 1'b0;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset", obs, w_idle);
    @(negedge clk);
    clear_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
      if (i == 1) check_val("dp_b_after_addi", {18'h0, dp_b}, {18'h0, 8'h0A});
    end

    // Valid held high while busy: only accepted again once back in IDLE.
    @(negedge clk);
    instr = 16'h2405; instr_valid = 1'b1;
    sb_q.push_back(ow(0, C_RAOUT | C_RZIN, 8'h05, 8'h00, 0, 0, 0));
    sb_q.push_back(ow(0, C_RZOUT | C_RBIN, 8'h00, 8'h00, 1, 0, 0));
    sb_q.push_back(w_idle);
    sb_q.push_back(ow(0, C_RAIN, 8'h00, 8'h77, 1, 0, 0));
    @(posedge clk); #1;
    instr = 16'h1077;
    check_out("busy.s1");
    @(posedge clk); #1; check_out("busy.s2");
    @(posedge clk); #1; check_out("busy.idle");
    @(posedge clk); #1; instr_valid = 1'b0; check_out("busy.ldia77");
    @(posedge clk); #1; check_val("busy.end", obs, w_idle);

    // Reset during ADDI STEP1 drops the instruction.
    @(negedge clk);
    instr = 16'h2405; instr_valid = 1'b1;
    sb_q.push_back(ow(0, C_RAOUT | C_RZIN, 8'h05, 8'h00, 0, 0, 0));
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check_out("rst_mid.s1");
    clear_n = 1'b0;
    @(posedge clk); #1;
    check_val("rst_mid.cleared", obs, w_idle);
    clear_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_mid.still_idle", obs, w_idle);
    run_vec('{"ldia3", 16'h1003, 2, ow(0, C_RAIN, 8'h00, 8'h03, 1, 0, 0), w_idle, w_idle});

    // HALT holds off everything until reset.
    @(negedge clk);
    instr = 16'hF000; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = 16'h1011;
    check_val("halt.enter", obs, w_halt);
    for (int k = 0; k < 22; k++) begin
      @(posedge clk); #1;
      check_val($sformatf("halt.hold%0d", k), obs, w_halt);
    end
    instr_valid = 1'b0;
    clear_n = 1'b0;
    @(posedge clk); #1;
    check_val("halt.recover", obs, w_idle);
    clear_n = 1'b1;
    run_vec('{"ldia_post_halt", 16'h1042, 2, ow(0, C_RAIN, 8'h00, 8'h42, 1, 0, 0), w_idle, w_idle});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Control sequencer that drives the datapath's register-transfer control inputs: RAin, RBin, RZin, RAout, RBout, RZout, AddImmediate and RegisterAImmediate.
- Accepts one 16-bit instruction at a time over a valid/ready handshake, decodes it, and steps the datapath through a fixed micro-step sequence, one control word per clock.
- Replaces hand-driven bench sequencing; its outputs connect directly to the datapath's control ports.

Parameters:
- IMM_W, 8, width of AddImmediate, RegisterAImmediate and the instruction immediate field.
- INSTR_W, 16, instruction width; fixed at IMM_W+8.

Ports:
- clock, input, 1, single clock; all logic on its rising edge.
- clear_n, input, 1, reset; synchronous, active-low.
- instr, input, INSTR_W, fields: opcode[15:12], rd[11:10], rs[9:8], imm[7:0].
- instr_valid, input, 1, instr is valid this cycle.
- instr_ready, output, 1, sequencer can accept an instruction.
- RAin / RBin / RZin, output, 1 each, register load enables.
- RAout / RBout / RZout, output, 1 each, register bus drive enables.
- AddImmediate, output, IMM_W, immediate operand to the adder.
- RegisterAImmediate, output, IMM_W, immediate load value for register A.
- done, output, 1, one-cycle pulse on the last micro-step of a legal instruction.
- err, output, 1, one-cycle pulse when an illegal instruction is accepted.
- halted, output, 1, high while in HALT.

Behaviour:
- All outputs are registered.
- Reset (clear_n=0 at a rising edge), including mid-sequence: next cycle all control outputs, done, err and halted are 0; instr_ready=1; state=IDLE; any in-flight instruction is dropped.
- Instruction is accepted when instr_valid && instr_ready at a rising edge. instr is latched; instr_ready drops in the following cycle.
- Register select encoding: 0=A, 1=B; 2 and 3 are illegal.
- States: IDLE, STEP1, STEP2, HALT.
- NOP (0x0): STEP1 only, with no controls asserted; done asserted in STEP1.
- LDIA (0x1): STEP1 drives RegisterAImmediate=imm and RAin=1; done asserted. rd and rs are ignored.
- ADDI (0x2):
  - STEP1: drive rs out (RAout or RBout), AddImmediate=imm, RZin=1.
  - STEP2: RZout=1, rd in (RAin or RBin), done=1.
- MV (0x3): same as ADDI with AddImmediate=0. rd==rs is legal.
- HALT (0xF): enter HALT; halted=1; instr_ready=0 until reset. No done pulse.
- Any other opcode, or rd/rs=2 or 3 on ADDI/MV: err=1 for one cycle in STEP1, no controls asserted, then IDLE.
- Return to IDLE the cycle after the final step. instr_ready=1 in IDLE only; there is no back-to-back acceptance.
- Latency from accept edge:
  - Controls appear in the next cycle.
  - A 1-step instruction occupies 2 cycles including IDLE.
  - A 2-step instruction occupies 3 cycles.
- Invariants:
  - Every control is asserted for exactly one cycle per step.
  - At most one *out signal is high in any cycle.
  - AddImmediate and RegisterAImmediate are 0 whenever not used by the current step.
  - instr_valid while instr_ready=0 is ignored and does not need to be held.

Optional Feature:
- Macro: DATAPATH_CTRL_DIRECT_MV_EN.
- Defined: MV completes in STEP1 by driving rs out and rd in in the same cycle (direct bus transfer, Z untouched). done is asserted in STEP1; total 2 cycles.
- Undefined: MV routes through Z as above (3 cycles).
- ADDI is unaffected either way.

Decomposition:
- Package datapath_ctrl_pkg:
  - opcode constants: OP_NOP, OP_LDIA, OP_ADDI, OP_MV, OP_HALT.
  - register select constants: SEL_A, SEL_B.
  - state enum.
  - control-word struct: six enables plus two immediates.
- Sub-module datapath_ctrl_decode: combinational. Maps latched instr and state to the next control word, done, err and next state. The top holds the state and output registers.

Test Plan:
- Reset then LDIA imm=0x05 → one cycle later RegisterAImmediate=0x05, RAin=1, done=1; the following cycle all controls are 0 and instr_ready=1.
- ADDI rd=B, rs=A, imm=0x05:
  - STEP1: RAout=1, AddImmediate=0x05, RZin=1.
  - STEP2: RZout=1, RBin=1, done=1.
  - Verify with the datapath instantiated: B=0x0A after LDIA 5.
- MV rd=A, rs=B → RBout+RZin with AddImmediate=0, then RZout+RAin. With DATAPATH_CTRL_DIRECT_MV_EN: RBout+RAin in one cycle, done in the same cycle.
- Opcode 0x7, and ADDI with rd=3 → err pulses once, no enables asserted, instr_ready returns after 1 cycle.
- clear_n=0 during ADDI STEP1 → next cycle all outputs 0 and instr_ready=1; a subsequent LDIA 0x03 executes normally.
- HALT → halted=1 and instr_ready=0 for 20+ cycles despite instr_valid=1; clear_n pulse recovers.
